// File: rtl/regif_rr_arb.sv
// regif_rr_arb: round-robin arbiter that shares one upstream register-interface
// channel turn among NUM_REQ clients.
// Optional hold watchdog: define REGIF_ARB_TIMEOUT_EN to build it.
// Without the macro, HOLD waits for every drvn bit to drop and timeout_err is 0.

module regif_rr_arb #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               reg_int_clk,
  input  logic               reg_int_reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] drvn,
  output logic [NUM_REQ-1:0] trn,
  output logic [ID_W-1:0]    grant_id,
  output logic               chn_reqep,
  input  logic               chn_trn,
  output logic               chn_drvn,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GUARD = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [3:0]         GUARD_LOAD  = 4'(GUARD_CYCLES - 1);
  localparam logic [ID_W-1:0]    PTR_RESET   = ID_W'(NUM_REQ - 1);

  // Reject parameter sets the arbiter cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_W != $clog2(NUM_REQ) ||
      GUARD_CYCLES < 1 || GUARD_CYCLES > 15 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("regif_rr_arb: illegal parameter combination");
  end

  state_t               state_r;
  logic [ID_W-1:0]      ptr_r;
  logic [3:0]           guard_cnt_r;
  logic [NUM_REQ-1:0]   trn_r;
  logic [ID_W-1:0]      grant_id_r;
  logic                 chn_reqep_r;
  logic                 chn_drvn_r;
  logic                 busy_r;

  logic [ID_W-1:0]      win_s;
  logic                 win_vld_s;
  logic [ID_W:0]        idx_s;

`ifdef REGIF_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]          to_cnt_r;
  logic                 timeout_err_r;
`endif

  // Round-robin scan: first requesting client after the pointer, wrapping.
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    idx_s     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s = {1'b0, ptr_r} + (ID_W+1)'(i);
      if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_s = idx_s - (ID_W+1)'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!win_vld_s && req[idx_s[ID_W-1:0]]) begin
        win_s     = idx_s[ID_W-1:0];
        win_vld_s = 1'b1;
      end else begin
        win_s     = win_s;
        win_vld_s = win_vld_s;
      end
    end
  end

  // Arbiter FSM with all outputs registered; trn defaults to 0 so it pulses once.
  always_ff @(posedge reg_int_clk) begin
    if (!reg_int_reset_n) begin
      state_r       <= IDLE;
      ptr_r         <= PTR_RESET;
      guard_cnt_r   <= 4'd0;
      trn_r         <= '0;
      grant_id_r    <= '0;
      chn_reqep_r   <= 1'b0;
      chn_drvn_r    <= 1'b0;
      busy_r        <= 1'b0;
`ifdef REGIF_ARB_TIMEOUT_EN
      to_cnt_r      <= 16'd0;
      timeout_err_r <= 1'b0;
`endif
    end else begin
      trn_r <= '0;
      case (state_r)
        IDLE: begin
          if (|req) begin
            state_r     <= REQ;
            chn_reqep_r <= 1'b1;
            busy_r      <= 1'b1;
          end else begin
            state_r     <= IDLE;
          end
        end
        REQ: begin
          if (chn_trn && win_vld_s) begin
            state_r     <= GUARD;
            guard_cnt_r <= GUARD_LOAD;
            trn_r       <= ONE_HOT_LSB << win_s;
            grant_id_r  <= win_s;
            ptr_r       <= win_s;
            chn_reqep_r <= 1'b0;
            chn_drvn_r  <= 1'b1;
          end else if (chn_trn || !(|req)) begin
            // Turn offered with nobody asking, or everyone withdrew.
            state_r     <= IDLE;
            chn_reqep_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r     <= REQ;
          end
        end
        GUARD: begin
          // drvn is not yet trustworthy while clients raise it.
          if (guard_cnt_r == 4'd0) begin
            state_r     <= HOLD;
          end else begin
            guard_cnt_r <= guard_cnt_r - 4'd1;
          end
        end
        HOLD: begin
          if (drvn == '0) begin
            state_r    <= IDLE;
            chn_drvn_r <= 1'b0;
            busy_r     <= 1'b0;
`ifdef REGIF_ARB_TIMEOUT_EN
            to_cnt_r   <= 16'd0;
`endif
          end
`ifdef REGIF_ARB_TIMEOUT_EN
          else if (to_cnt_r == TO_LAST) begin
            state_r       <= IDLE;
            chn_drvn_r    <= 1'b0;
            busy_r        <= 1'b0;
            to_cnt_r      <= 16'd0;
            timeout_err_r <= 1'b1;
          end else begin
            to_cnt_r      <= to_cnt_r + 16'd1;
          end
`else
          else begin
            state_r <= HOLD;
          end
`endif
        end
        default: begin
          state_r     <= IDLE;
          chn_reqep_r <= 1'b0;
          chn_drvn_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign trn       = trn_r;
  assign grant_id  = grant_id_r;
  assign chn_reqep = chn_reqep_r;
  assign chn_drvn  = chn_drvn_r;
  assign busy      = busy_r;
`ifdef REGIF_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_regif_rr_arb.sv
// Self-checking bench for regif_rr_arb (NUM_REQ=4, GUARD_CYCLES=2).
// Grant vectors come from a table; corner cases are hand-written sequences.
// Expected winners are queued when chn_trn is driven and popped at the trn pulse.

module tb_regif_rr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] drvn;
  logic [3:0] trn;
  logic [1:0] grant_id;
  logic       chn_reqep;
  logic       chn_trn;
  logic       chn_drvn;
  logic       busy;
  logic       timeout_err;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  logic prev_drvn = 1'b0;

  typedef struct {
    logic [3:0] req;
    int         win;
    int         hold;
  } vec_t;
  vec_t tbl[16];

  regif_rr_arb #(
    .NUM_REQ(4), .ID_W(2), .GUARD_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .reg_int_clk(clk), .reg_int_reset_n(rst_n), .req(req), .drvn(drvn),
    .trn(trn), .grant_id(grant_id), .chn_reqep(chn_reqep), .chn_trn(chn_trn),
    .chn_drvn(chn_drvn), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    chk("inv_onehot0", 32'($onehot0(trn)), 32'd1);
    chk("inv_excl", 32'(chn_reqep & chn_drvn), 32'd0);
    if (trn != 4'd0) chk("inv_trn_rise", {30'd0, prev_drvn, chn_drvn}, 32'd1);
    prev_drvn = chn_drvn;
  end

  // Pop the expected winner and compare the pulse that should be present now.
  task automatic check_grant();
    int e;
    logic [3:0] one;
    one = 4'b0001;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trn", 32'(trn), 32'(one << e));
      chk("grant_id", 32'(grant_id), 32'(e));
    end else begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end
    chk("drvn_rise", 32'(chn_drvn), 32'd1);
    chk("reqep_fall", 32'(chn_reqep), 32'd0);
  endtask

  task automatic do_grant(input logic [3:0] r, input int win, input int hold);
    logic [3:0] one;
    one = 4'b0001;
    req = r;
    tick();
    chk("reqep_rise", 32'(chn_reqep), 32'd1);
    chk("busy_req", 32'(busy), 32'd1);
    tick();
    tick();
    chk("reqep_hold", 32'(chn_reqep), 32'd1);
    chn_trn = 1'b1;
    exp_q.push_back(win);
    tick();
    chn_trn = 1'b0;
    check_grant();
    drvn = one << win;
    for (int k = 0; k < hold; k++) begin
      tick();
      if (k == 0) chk("trn_one_cycle", 32'(trn), 32'd0);
    end
    chk("drvn_held", 32'(chn_drvn), 32'd1);
    drvn = 4'd0;
    tick();
    chk("drvn_fall", 32'(chn_drvn), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; drvn = 4'd0; chn_trn = 1'b0;
    tick();
    tick();
    chk("rst_trn", 32'(trn), 32'd0);
    chk("rst_reqep", 32'(chn_reqep), 32'd0);
    chk("rst_drvn", 32'(chn_drvn), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // Fairness from reset, then single client, skip/wrap, sparse mask.
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, i % 4, 2};
    tbl[8]  = '{4'b0001, 0, 5};
    tbl[9]  = '{4'b0100, 2, 2};
    tbl[10] = '{4'b0011, 0, 2};
    tbl[11] = '{4'b0011, 1, 2};
    tbl[12] = '{4'b0011, 0, 2};
    tbl[13] = '{4'b1010, 1, 2};
    tbl[14] = '{4'b1010, 3, 2};
    tbl[15] = '{4'b1010, 1, 2};
    for (int i = 0; i < 16; i++) do_grant(tbl[i].req, tbl[i].win, tbl[i].hold);

    // Withdrawal before chn_trn.
    req = 4'b0100;
    tick();
    chk("wd_reqep", 32'(chn_reqep), 32'd1);
    req = 4'd0;
    tick();
    chk("wd_reqep_fall", 32'(chn_reqep), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    // chn_trn in IDLE is ignored.
    chn_trn = 1'b1;
    tick();
    chn_trn = 1'b0;
    chk("idle_trn_busy", 32'(busy), 32'd0);
    chk("idle_trn_drvn", 32'(chn_drvn), 32'd0);
    // req drop in the same cycle as chn_trn.
    req = 4'b0100;
    tick();
    tick();
    req = 4'd0;
    chn_trn = 1'b1;
    tick();
    chn_trn = 1'b0;
    chk("drop_trn", 32'(trn), 32'd0);
    chk("drop_drvn", 32'(chn_drvn), 32'd0);
    chk("drop_reqep", 32'(chn_reqep), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_gid_hold", 32'(grant_id), 32'd1);
    // Pointer did not move (still 1).
    do_grant(4'b1111, 2, 2);

    // Reset during HOLD.
    req = 4'b0010;
    tick();
    tick();
    tick();
    chn_trn = 1'b1;
    exp_q.push_back(1);
    tick();
    chn_trn = 1'b0;
    check_grant();
    drvn = 4'b0010;
    repeat (4) tick();
    chk("mid_hold", 32'(chn_drvn), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_drvn", 32'(chn_drvn), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gid", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    drvn = 4'd0;
    do_grant(4'b1111, 0, 2);
    do_grant(4'b1000, 3, 2);

    // Stuck drvn, from a fresh reset (pointer 3, so client 1 wins).
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = 4'b0010;
    tick();
    tick();
    tick();
    chn_trn = 1'b1;
    exp_q.push_back(1);
    tick();
    chn_trn = 1'b0;
    check_grant();
    drvn = 4'b0010;
    req = 4'd0;
`ifdef REGIF_ARB_TIMEOUT_EN
    repeat (17) tick();
    chk("tmo_before", 32'(chn_drvn), 32'd1);
    chk("tmo_flag_before", 32'(timeout_err), 32'd0);
    tick();
    chk("tmo_drvn", 32'(chn_drvn), 32'd0);
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    drvn = 4'd0;
    do_grant(4'b0001, 0, 2);
    chk("tmo_sticky", 32'(timeout_err), 32'd1);
`else
    repeat (40) tick();
    chk("stuck_drvn", 32'(chn_drvn), 32'd1);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_tmo", 32'(timeout_err), 32'd0);
    drvn = 4'd0;
    tick();
    chk("stuck_release", 32'(chn_drvn), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
